// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file definitions and encodings for the writeback arbiter.
// RegBus/RegAddrBus give the default data/address widths.
package regfile_wb_arbiter_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin selector: grants the first asserted request after the pointer,
// wrapping around; the grant is one-hot or zero.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    // Offset 1..NUM_REQ so the last winner is searched last.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle (round-robin, with a
// same-address override for ordering) and registers it onto the RF write port.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = RegBus,
  parameter int unsigned ADDR_W  = RegAddrBus
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  input  logic [ADDR_W-1:0]         pend_addr,
  output logic                      pend_hit
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  logic [PtrW-1:0]    last_grant;
  logic [NUM_REQ-1:0] rr_grant;
  logic [NUM_REQ-1:0] ovr_grant;
  logic [NUM_REQ-1:0] grant;
  logic               ovr_hit;
  logic [PtrW-1:0]    gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               req_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req  (req_valid),
    .ptr  (last_grant),
    .grant(rr_grant)
  );

  // The lowest index of any same-address group holds the oldest value and must land first.
  always_comb begin
    ovr_grant = '0;
    ovr_hit   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (!ovr_hit && req_valid[i] && req_valid[j] &&
            req_addr[i*ADDR_W +: ADDR_W] != '0 &&
            req_addr[i*ADDR_W +: ADDR_W] == req_addr[j*ADDR_W +: ADDR_W]) begin
          ovr_hit      = 1'b1;
          ovr_grant[i] = 1'b1;
        end
      end
    end
  end

  assign grant     = (rst == RstEnable) ? '0 : (ovr_hit ? ovr_grant : rr_grant);
  assign req_ready = grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    gnt_idx  = '0;
    req_hit  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
        gnt_idx  = PtrW'(i);
      end
      if (req_valid[i] && req_addr[i*ADDR_W +: ADDR_W] == pend_addr) begin
        req_hit = 1'b1;
      end
    end
  end

  assign pend_hit = (rst != RstEnable) && (pend_addr != '0) &&
                    (req_hit || (we == WriteEnable && waddr == pend_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      we         <= WriteDisable;
      waddr      <= '0;
      wdata      <= DATA_W'(ZeroWord);
      last_grant <= PtrW'(NUM_REQ - 1);
    end else begin
      // x0 transfers are accepted but never reach the register file.
      if (|grant && sel_addr != '0) begin
        we    <= WriteEnable;
        waddr <= sel_addr;
        wdata <= sel_data;
      end else begin
        we    <= WriteDisable;
        waddr <= '0;
        wdata <= DATA_W'(ZeroWord);
      end
      if (|grant && !ovr_hit) begin
        last_grant <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with NUM_REQ=2, hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  pend_addr;
  logic        pend_hit;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(
    .NUM_REQ(2),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .pend_addr(pend_addr),
    .pend_hit (pend_hit)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
  endtask

  task automatic check_out(input string tag, input logic e_we, input logic [4:0] e_a,
                           input logic [31:0] e_d);
    check_eq({tag, ".we"}, 64'(we), 64'(e_we));
    check_eq({tag, ".waddr"}, 64'(waddr), 64'(e_a));
    check_eq({tag, ".wdata"}, 64'(wdata), 64'(e_d));
  endtask

  initial begin
    rst       = 1'b1;
    pend_addr = 5'd3;
    drive(2'b11, 5'd3, 32'hA, 5'd7, 32'hB);

    // Held in reset with live requests: nothing may be granted or written.
    step();
    step();
    check_out("rst", 1'b0, 5'd0, 32'd0);
    check_eq("rst.ready", 64'(req_ready), 64'd0);
    check_eq("rst.pend_hit", 64'(pend_hit), 64'd0);

    // Release: index 0 searched first.
    rst       = 1'b0;
    pend_addr = 5'd0;
    #1;
    check_eq("rel.ready0", 64'(req_ready), 64'b01);
    step();
    drive(2'b10, 5'd3, 32'hA, 5'd7, 32'hB);
    check_out("rel.out0", 1'b1, 5'd3, 32'hA);
    check_eq("rel.ready1", 64'(req_ready), 64'b10);
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_out("rel.out1", 1'b1, 5'd7, 32'hB);
    check_eq("rel.idle_ready", 64'(req_ready), 64'd0);
    step();
    check_eq("rel.idle_we", 64'(we), 64'd0);

    // Two streaming requesters alternate 0,1,0,1 with no bubbles.
    drive(2'b11, 5'd1, 32'h100, 5'd2, 32'h200);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("alt.ready%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
      step();
      check_out($sformatf("alt.out%0d", i), 1'b1, (i % 2 == 0) ? 5'd1 : 5'd2,
                (i % 2 == 0) ? 32'h100 : 32'h200);
    end
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    step();
    check_eq("alt.idle_we", 64'(we), 64'd0);

    // Override grant must leave the pointer alone (last grant is still 1).
    drive(2'b11, 5'd6, 32'h33, 5'd6, 32'h44);
    check_eq("ovr.ready", 64'(req_ready), 64'b01);
    step();
    check_out("ovr.out", 1'b1, 5'd6, 32'h33);
    drive(2'b11, 5'd8, 32'h55, 5'd6, 32'h44);
    check_eq("ovr.ptr_kept", 64'(req_ready), 64'b01);
    step();
    check_out("ovr.out2", 1'b1, 5'd8, 32'h55);
    drive(2'b10, 5'd0, 32'd0, 5'd6, 32'h44);
    check_eq("ovr.ready3", 64'(req_ready), 64'b10);
    step();
    check_out("ovr.out3", 1'b1, 5'd6, 32'h44);

    // Pointer now favours req1; same-address x5 still lands req0 first.
    drive(2'b01, 5'd4, 32'h66, 5'd0, 32'd0);
    step();
    check_out("x5.pre", 1'b1, 5'd4, 32'h66);
    drive(2'b11, 5'd5, 32'h11, 5'd5, 32'h22);
    check_eq("x5.ready0", 64'(req_ready), 64'b01);
    step();
    check_out("x5.first", 1'b1, 5'd5, 32'h11);
    drive(2'b10, 5'd0, 32'd0, 5'd5, 32'h22);
    check_eq("x5.ready1", 64'(req_ready), 64'b10);
    step();
    check_out("x5.final", 1'b1, 5'd5, 32'h22);

    // Write to x0 is accepted but suppressed.
    drive(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0);
    check_eq("x0.ready", 64'(req_ready), 64'b01);
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_out("x0.out", 1'b0, 5'd0, 32'd0);

    // Hazard query tracks the pending x9 write through its output cycle.
    pend_addr = 5'd9;
    drive(2'b10, 5'd0, 32'd0, 5'd9, 32'h99);
    check_eq("pend.req", 64'(pend_hit), 64'd1);
    check_eq("pend.ready", 64'(req_ready), 64'b10);
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    check_eq("pend.we", 64'(we), 64'd1);
    check_eq("pend.out", 64'(pend_hit), 64'd1);
    step();
    check_eq("pend.done", 64'(pend_hit), 64'd0);
    pend_addr = 5'd0;
    drive(2'b10, 5'd0, 32'd0, 5'd0, 32'h5);
    check_eq("pend.zero", 64'(pend_hit), 64'd0);
    step();
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

    // Asynchronous reset between edges kills the registered write at once.
    drive(2'b01, 5'd12, 32'h77, 5'd0, 32'd0);
    step();
    check_eq("arst.before", 64'(we), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst.we_drop", 64'(we), 64'd0);
    check_eq("arst.ready", 64'(req_ready), 64'd0);
    step();
    check_eq("arst.hold", 64'(we), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("arst.after", 64'(we), 64'd0);
    check_eq("arst.regrant", 64'(req_ready), 64'b01);
    step();
    check_out("arst.new", 1'b1, 5'd12, 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
